// File: rtl/axi_write_master.sv
// AXI3 write-channel initiator: one outstanding burst at a time (AW, then W beats, then B).
// Beats are forwarded from the local device with a one-deep W output register.
module axi_write_master #(
  parameter int buswidth  = 32,
  parameter int strbwidth = buswidth / 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_id,
  input  logic [31:0]          req_addr,
  input  logic [3:0]           req_len,
  input  logic [2:0]           req_size,
  input  logic [1:0]           req_burst,
  input  logic [buswidth-1:0]  wr_data,
  input  logic [strbwidth-1:0] wr_strb,
  input  logic                 wr_data_valid,
  output logic                 wr_data_ready,
  output logic                 done,
  output logic [1:0]           done_resp,
  output logic [3:0]           AWID,
  output logic [31:0]          AWADDR,
  output logic [3:0]           AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic [1:0]           AWLOCK,
  output logic [3:0]           AWCACHE,
  output logic [2:0]           AWPROT,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [3:0]           WID,
  output logic [buswidth-1:0]  WDATA,
  output logic [strbwidth-1:0] WSTRB,
  output logic                 WLAST,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic [3:0]           BID,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t               state, state_nxt;
  logic [4:0]           count, count_nxt;
  logic [3:0]           awid_nxt, awlen_nxt, wid_nxt;
  logic [31:0]          awaddr_nxt;
  logic [2:0]           awsize_nxt;
  logic [1:0]           awburst_nxt, done_resp_nxt;
  logic                 awvalid_nxt, wvalid_nxt, wlast_nxt, bready_nxt, done_nxt;
  logic [buswidth-1:0]  wdata_nxt;
  logic [strbwidth-1:0] wstrb_nxt;
  logic                 load;

  assign AWLOCK  = 2'b00;
  assign AWCACHE = 4'b0000;
  assign AWPROT  = 3'b000;

  // Hold off a new request during the done cycle so completion and acceptance never overlap.
  assign req_ready     = (state == IDLE) && !done;
  // Count is one bit wider than AWLEN so a 16-beat burst terminates cleanly.
  assign wr_data_ready = (state == DATA) && (count <= {1'b0, AWLEN}) && (!WVALID || WREADY);
  assign load          = wr_data_valid && wr_data_ready;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      count     <= '0;
      AWID      <= '0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWSIZE    <= '0;
      AWBURST   <= '0;
      AWVALID   <= 1'b0;
      WID       <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WLAST     <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      done      <= 1'b0;
      done_resp <= 2'b00;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      AWID      <= awid_nxt;
      AWADDR    <= awaddr_nxt;
      AWLEN     <= awlen_nxt;
      AWSIZE    <= awsize_nxt;
      AWBURST   <= awburst_nxt;
      AWVALID   <= awvalid_nxt;
      WID       <= wid_nxt;
      WDATA     <= wdata_nxt;
      WSTRB     <= wstrb_nxt;
      WLAST     <= wlast_nxt;
      WVALID    <= wvalid_nxt;
      BREADY    <= bready_nxt;
      done      <= done_nxt;
      done_resp <= done_resp_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    awid_nxt      = AWID;
    awaddr_nxt    = AWADDR;
    awlen_nxt     = AWLEN;
    awsize_nxt    = AWSIZE;
    awburst_nxt   = AWBURST;
    awvalid_nxt   = AWVALID;
    wid_nxt       = WID;
    wdata_nxt     = WDATA;
    wstrb_nxt     = WSTRB;
    wlast_nxt     = WLAST;
    wvalid_nxt    = WVALID;
    bready_nxt    = BREADY;
    done_nxt      = 1'b0;
    done_resp_nxt = done_resp;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          awid_nxt    = req_id;
          awaddr_nxt  = req_addr;
          awlen_nxt   = req_len;
          awsize_nxt  = req_size;
          awburst_nxt = req_burst;
          awvalid_nxt = 1'b1;
          count_nxt   = '0;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (AWREADY) begin
          awvalid_nxt = 1'b0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (WVALID && WREADY && WLAST) begin
          wvalid_nxt = 1'b0;
          wlast_nxt  = 1'b0;
          bready_nxt = 1'b1;
          state_nxt  = RESP;
        end else if (load) begin
          wdata_nxt  = wr_data;
          wstrb_nxt  = wr_strb;
          wid_nxt    = AWID;
          wvalid_nxt = 1'b1;
          wlast_nxt  = (count == {1'b0, AWLEN});
          count_nxt  = count + 5'd1;
        end else if (WVALID && WREADY) begin
          wvalid_nxt = 1'b0;
          wlast_nxt  = 1'b0;
        end
      end
      RESP: begin
        if (BVALID) begin
          bready_nxt    = 1'b0;
          done_nxt      = 1'b1;
          done_resp_nxt = (BID == AWID) ? BRESP : 2'b10;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        wlast_nxt   = 1'b0;
        bready_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_write_master.sv
// Directed bench for axi_write_master: a table of burst scenarios driven against a
// cycle-by-cycle slave/device model, plus reset-state and reset-mid-burst sequences.
module tb_axi_write_master;

  logic        ACLK, ARESETn;
  logic        req_valid, req_ready;
  logic [3:0]  req_id, req_len;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_data_valid, wr_data_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic [3:0]  AWID, AWLEN, AWCACHE, WID, WSTRB, BID;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWSIZE, AWPROT;
  logic [1:0]  AWBURST, AWLOCK, BRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  int errors = 0;
  int checks = 0;

  axi_write_master #(.buswidth(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .done(done), .done_resp(done_resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] dbase;
    logic [3:0]  strb;
    int          awdelay;
    bit          wstall;
    bit          dgap;
    int          bdelay;
    logic [1:0]  bresp;
    bit          bid_bad;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_id = 0; req_addr = 0; req_len = 0; req_size = 0; req_burst = 0;
    wr_data = 0; wr_strb = 0; wr_data_valid = 0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
  endtask

  task automatic run_burst(input vec_t v, input int idx);
    int aw_hi = 0, w_hs = 0, beat_ld = 0, b_wait = 0, done_cnt = 0;
    bit aw_done = 0, last_seen = 0, b_hs = 0, post = 0, exp_wvalid = 0;
    bit exp_rdy, load, prev_stall = 0;
    logic [31:0] prev_wdata = '0;
    string p = $sformatf("v%0d_", idx);

    @(negedge ACLK);
    check({p, "req_ready_idle"}, req_ready, 1);
    req_valid = 1; req_id = v.id; req_addr = v.addr; req_len = v.len;
    req_size = v.size; req_burst = v.burst;
    @(negedge ACLK);
    req_valid = 0; req_id = ~v.id; req_addr = ~v.addr; req_len = ~v.len;
    req_size = ~v.size; req_burst = ~v.burst;
    check({p, "awvalid_after_req"}, AWVALID, 1);
    check({p, "req_ready_busy"}, req_ready, 0);

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (post) begin
        check({p, "done_one_pulse"}, done, 0);
        break;
      end
      if (done) begin
        done_cnt++;
        check({p, "done_resp"}, done_resp, v.exp_resp);
        check({p, "no_accept_with_done"}, req_ready, 0);
        check({p, "bready_drop"}, BREADY, 0);
        post = 1;
      end
      check({p, "wvalid"}, WVALID, exp_wvalid);
      if (AWVALID) begin
        aw_hi++;
        check({p, "aw_payload"}, {AWID, AWADDR, AWLEN, AWSIZE, AWBURST},
              {v.id, v.addr, v.len, v.size, v.burst});
      end
      if (prev_stall) check({p, "wdata_stall_hold"}, WDATA, prev_wdata);
      if (last_seen && !b_hs) check({p, "bready_wait"}, BREADY, 1);

      AWREADY       = AWVALID && (aw_hi > v.awdelay);
      WREADY        = v.wstall ? (cyc % 2 == 1) : 1'b1;
      wr_data_valid = (beat_ld <= int'(v.len)) && !(v.dgap && (cyc % 3 == 0));
      wr_data       = v.dbase + beat_ld;
      wr_strb       = v.strb;
      BVALID        = last_seen && !b_hs && (b_wait >= v.bdelay);
      BID           = v.bid_bad ? (v.id ^ 4'h1) : v.id;
      BRESP         = v.bresp;
      if (last_seen && !b_hs && !BVALID) b_wait++;
      #1;

      exp_rdy = aw_done && (beat_ld <= int'(v.len)) && (!exp_wvalid || WREADY);
      check({p, "wr_data_ready"}, wr_data_ready, exp_rdy);
      load = wr_data_valid && exp_rdy;
      if (AWVALID && AWREADY) aw_done = 1;
      prev_stall = exp_wvalid && !WREADY;
      prev_wdata = WDATA;
      if (exp_wvalid && WREADY) begin
        check({p, "w_beat"}, {WID, WSTRB, WDATA}, {v.id, v.strb, v.dbase + w_hs});
        check({p, "wlast"}, WLAST, (w_hs == int'(v.len)));
        if (w_hs == int'(v.len)) last_seen = 1;
        w_hs++;
      end
      if (load) begin
        exp_wvalid = 1;
        beat_ld++;
      end else if (exp_wvalid && WREADY) begin
        exp_wvalid = 0;
      end
      if (BVALID && BREADY) b_hs = 1;
      @(negedge ACLK);
    end

    check({p, "aw_cycles"}, aw_hi, v.awdelay + 1);
    check({p, "w_handshakes"}, w_hs, int'(v.len) + 1);
    check({p, "done_count"}, done_cnt, 1);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    //          id     addr          len   size  burst dbase          strb  awd ws dg bd bresp bidbad exp
    tbl[0] = '{4'd3, 32'h0000_0100, 4'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 0, 2'b00};
    tbl[1] = '{4'd5, 32'h0000_2000, 4'd3, 3'd2, 2'b01, 32'h0000_0001, 4'hF, 0, 1, 0, 0, 2'b00, 0, 2'b00};
    tbl[2] = '{4'd7, 32'h0000_3000, 4'd1, 3'd2, 2'b01, 32'h5500_0000, 4'h3, 5, 0, 0, 0, 2'b00, 0, 2'b00};
    tbl[3] = '{4'd9, 32'h0000_4000, 4'd15, 3'd2, 2'b01, 32'h0000_1000, 4'hF, 0, 0, 1, 0, 2'b00, 0, 2'b00};
    tbl[4] = '{4'd2, 32'h0000_5000, 4'd1, 3'd2, 2'b01, 32'hA0A0_0000, 4'hF, 0, 0, 0, 0, 2'b10, 0, 2'b10};
    tbl[5] = '{4'd4, 32'h0000_6000, 4'd0, 3'd2, 2'b01, 32'hB0B0_0000, 4'hF, 0, 0, 0, 0, 2'b00, 1, 2'b10};
    tbl[6] = '{4'd6, 32'h0000_7000, 4'd2, 3'd2, 2'b00, 32'hC0C0_0000, 4'hC, 0, 0, 0, 4, 2'b00, 0, 2'b00};
    tbl[7] = '{4'hE, 32'h0000_0040, 4'd7, 3'd2, 2'b10, 32'h1234_0000, 4'h5, 2, 1, 1, 1, 2'b01, 0, 2'b01};

    idle_inputs();
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    check("rst_valids", {AWVALID, WVALID, WLAST, BREADY, done}, 5'b0);
    check("rst_payload", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, WID, WDATA, WSTRB, done_resp}, '0);
    check("rst_consts", {AWLOCK, AWCACHE, AWPROT}, 9'b0);
    check("rst_req_ready", req_ready, 1);
    check("rst_wr_data_ready", wr_data_ready, 0);
    ARESETn = 1;

    for (int i = 0; i < 8; i++) run_burst(tbl[i], i);

    // Reset after the second beat of a four-beat burst, then a clean burst.
    @(negedge ACLK);
    req_valid = 1; req_id = 4'd8; req_addr = 32'h8000; req_len = 4'd3;
    req_size = 3'd2; req_burst = 2'b01; AWREADY = 1; WREADY = 1;
    @(negedge ACLK);
    req_valid = 0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      wr_data_valid = 1; wr_data = 32'hA0 + c; wr_strb = 4'hF;
      #1;
      if (WVALID && WREADY) hs++;
      @(negedge ACLK);
    end
    check("rstmid_beats", hs, 2);
    ARESETn = 0;
    idle_inputs();
    @(negedge ACLK);
    check("rstmid_valids", {AWVALID, WVALID, BREADY}, 3'b0);
    check("rstmid_req_ready", req_ready, 1);
    check("rstmid_done", done, 0);
    ARESETn = 1;
    BVALID = 1; BID = 4'd8;
    @(negedge ACLK);
    check("rstmid_no_done", done, 0);
    check("rstmid_idle", {AWVALID, WVALID, BREADY}, 3'b0);
    BVALID = 0;
    run_burst(tbl[0], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- AXI3 write-channel initiator. It takes a burst request and per-beat data from a local device, then drives the AW, W and B channels toward a write slave.
- Issues one outstanding burst at a time: address phase, then data beats, then response. It returns BRESP status to the device.
- Sits between the cache/DMA-side requester and the interconnect. It is the counterpart to the team's write slave.

Parameters:
- buswidth, 32, data width in bits of WDATA/wr_data. Must be a multiple of 8.
- strbwidth, buswidth/8, byte-strobe width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- req_valid  in  1  device burst request
- req_ready  out  1  master can accept a request
- req_id  in  4  transaction ID
- req_addr  in  32  start address
- req_len  in  4  beats minus 1
- req_size  in  3  bytes per beat, log2
- req_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- wr_data  in  buswidth  beat data
- wr_strb  in  strbwidth  beat byte enables
- wr_data_valid  in  1  device beat available
- wr_data_ready  out  1  beat consumed this cycle
- done  out  1  one-cycle pulse, burst complete
- done_resp  out  2  final response
- AWID  out  4
- AWADDR  out  32
- AWLEN  out  4
- AWSIZE  out  3
- AWBURST  out  2
- AWLOCK  out  2
- AWCACHE  out  4
- AWPROT  out  3
- AWVALID  out  1
- AWREADY  in  1
- WID  out  4
- WDATA  out  buswidth
- WSTRB  out  strbwidth
- WLAST  out  1
- WVALID  out  1
- WREADY  in  1
- BID  in  4
- BRESP  in  2
- BVALID  in  1
- BREADY  out  1

Behaviour:
- Clock and reset: ACLK is the clock. ARESETn is synchronous and active-low.
- All outputs except req_ready and wr_data_ready are registered.
- Reset values:
  - state IDLE.
  - AWVALID, WVALID, WLAST, BREADY, done all 0.
  - All payload registers 0, done_resp 00.
  - AWLOCK 00, AWCACHE 0000, AWPROT 000 are constants.
- Reset mid-burst: next edge returns to IDLE and all VALIDs drop. The partially issued burst is abandoned and no done pulse is generated.

States:
- IDLE
  - req_ready=1.
  - On req_valid: latch id/addr/len/size/burst into AW registers, set AWVALID=1, beat counter=0. Go to ADDR.
  - AWVALID is therefore high the cycle after acceptance.
- ADDR
  - Hold AWVALID and all AW payload stable until AWREADY.
  - On AWVALID&&AWREADY: AWVALID=0, go to DATA.
  - The first AWREADY-high cycle completes the handshake (one-cycle AWREADY is sufficient).
- DATA
  - wr_data_ready = (state==DATA) && (count<=len) && (!WVALID || WREADY). This is combinational.
  - On wr_data_valid&&wr_data_ready:
    - WDATA<=wr_data, WSTRB<=wr_strb, WID<=AWID, WVALID<=1.
    - WLAST<=(count==len); count increments.
  - On WVALID&&WREADY with no new beat loaded: WVALID<=0, WLAST<=0.
  - A new beat may load in the same cycle the previous beat handshakes, giving back-to-back beats at one per cycle.
  - WVALID and payload are held stable while WREADY is low.
  - Device stall (wr_data_valid=0) leaves WVALID low. No bubble data is ever issued.
  - On WVALID&&WREADY&&WLAST: WVALID=0, BREADY<=1, go to RESP.
- RESP
  - BREADY=1.
  - On BVALID:
    - BREADY<=0, done<=1 for one cycle.
    - done_resp<=BRESP if BID==latched ID, else 2'b10 (SLVERR).
    - Go to IDLE.
- Any other encoding goes to IDLE.

Additional rules:
- Beat counter is 5 bits so len=15 (16 beats) does not wrap before the final compare. Exactly len+1 beats are issued per burst.
- The address is not advanced by the master. The slave computes beat addresses from AWADDR/AWSIZE/AWBURST.
- VALID never depends combinationally on READY.
- req_ready is low in every state except IDLE. A request asserted mid-burst waits.
- Simultaneous done pulse and new req_valid: the next request is accepted only on the cycle after returning to IDLE, so done and req acceptance never coincide.

Test Plan:
- Single beat:
  - Stimulus: req id=3, addr=0x100, len=0, INCR, size=2, data 0xDEADBEEF, strb 0xF; slave always ready.
  - Required: AWVALID one cycle after request with AWADDR=0x100, AWLEN=0; one W beat with WLAST=1, WID=3; BVALID with BID=3, BRESP=00; done=1 with done_resp=00.
- Four-beat burst with WREADY stalls:
  - Stimulus: len=3, data 0x1..0x4, WREADY low on alternate cycles.
  - Required: beats delivered in order 1,2,3,4; WDATA stable during every stall; WLAST only on 0x4; exactly 4 W handshakes.
- AWREADY delayed 5 cycles:
  - Required: AWVALID held for 6 cycles with constant payload; wr_data_ready stays 0 until the AW handshake completes.
- Device data stall and 16-beat burst:
  - Stimulus: len=15, wr_data_valid gapped.
  - Required: WVALID drops during gaps; 16 beats issued; WLAST only on beat 16; done pulses once.
- Response errors:
  - Stimulus A: BRESP=10 with BID matching. Required: done_resp=10.
  - Stimulus B: BRESP=00 with BID mismatching. Required: done_resp=10.
  - Stimulus C: BVALID delayed 4 cycles. Required: BREADY held high throughout.
- Reset mid-DATA:
  - Stimulus: ARESETn low after beat 2 of a 4-beat burst.
  - Required: next edge AWVALID=WVALID=BREADY=0, req_ready=1, no done pulse; a following burst completes normally.
